fetch_seq: RTL and testbench

//  Instruction-fetch sequencer. Owns the architectural PC register and fetches from imem over a req/gnt/rvalid handshake.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_target_calc.sv | 49 ++++
 rtl/fetch_seq.sv | 180 ++++++++++++++++++
 tb/tb_fetch_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect select codes, fetch FSM state encoding and
// the default reset PC used by the fetch sequencer.
package cpu_pkg;

   // Redirect select codes driven by execute
   localparam logic [1:0] PCSEL_SEQ = 2'b00;
   localparam logic [1:0] PCSEL_BEQ = 2'b01;
   localparam logic [1:0] PCSEL_J   = 2'b10;
   localparam logic [1:0] PCSEL_JR  = 2'b11;

   // Fetch FSM state encoding; FS_IDLE is only occupied directly after reset
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t FS_IDLE  = 2'd0;
   localparam fetch_state_t FS_REQ   = 2'd1;
   localparam fetch_state_t FS_WAIT  = 2'd2;
   localparam fetch_state_t FS_DELIV = 2'd3;

   localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;

endpackage : cpu_pkg

// File: rtl/pc_target_calc.sv
// Combinational redirect target calculator: turns the execute-stage redirect
// fields into a 32-bit target and a flag saying whether control flow changes.
module pc_target_calc
   import cpu_pkg::*;
(
   input  logic [1:0]  redir_sel_i,
   input  logic [31:0] redir_pc_i,
   input  logic [31:0] redir_imm_i,
   input  logic        redir_zero_i,
   input  logic [31:0] redir_base_i,
   output logic [31:0] target_o,
   output logic        taken_o
);

   logic [31:0] seq_pc;
   logic [31:0] beq_off;
   logic        unused_imm_hi;

   assign seq_pc        = redir_pc_i + 32'd4;
   assign beq_off       = {{14{redir_imm_i[15]}}, redir_imm_i[15:0], 2'b00};
   assign unused_imm_hi = ^redir_imm_i[31:26];

   // Select the target by redirect kind; untaken branches and seq fall through to pc+4
   always_comb begin
      target_o = seq_pc;
      taken_o  = 1'b0;
      case (redir_sel_i)
         PCSEL_BEQ: begin
            if (redir_zero_i) begin
               target_o = seq_pc + beq_off;
               taken_o  = 1'b1;
            end
         end
         PCSEL_J: begin
            target_o = {seq_pc[31:28], redir_imm_i[25:0], 2'b00};
            taken_o  = 1'b1;
         end
         PCSEL_JR: begin
            target_o = redir_base_i;
            taken_o  = 1'b1;
         end
         default: begin
            target_o = seq_pc;
            taken_o  = 1'b0;
         end
      endcase
   end

endmodule : pc_target_calc

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// hands instructions to decode and applies execute redirects, dropping any
// wrong-path response. Optional performance counters are built when the
// FETCH_PERF_EN macro is defined; otherwise perf_* are tied to zero.
module fetch_seq
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = CPU_RESET_PC,
   parameter int          AW       = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [31:0]   imem_rdata,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [31:0]   inst_word,
   output logic [AW-1:0] inst_pc,
   input  logic          redir_valid,
   input  logic [1:0]    redir_sel,
   input  logic [AW-1:0] redir_pc,
   input  logic [31:0]   redir_imm,
   input  logic          redir_zero,
   input  logic [AW-1:0] redir_base,
   output logic [31:0]   perf_fetch,
   output logic [31:0]   perf_flush
);

   fetch_state_t  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pend_pc_q, pend_pc_d;
   logic          pend_q, pend_d;
   logic          kill_q, kill_d;
   logic [31:0]   word_q, word_d;
   logic [AW-1:0] ipc_q, ipc_d;
   logic          fetch_inc;
   logic          flush_inc;

   logic [AW-1:0] redir_tgt;
   logic          redir_taken;
   logic          redir_eff;

   pc_target_calc u_pc_target_calc (
      .redir_sel_i  (redir_sel),
      .redir_pc_i   (redir_pc),
      .redir_imm_i  (redir_imm),
      .redir_zero_i (redir_zero),
      .redir_base_i (redir_base),
      .target_o     (redir_tgt),
      .taken_o      (redir_taken)
   );

   assign redir_eff  = redir_valid && redir_taken;

   assign imem_req   = (state_q == FS_REQ);
   assign imem_addr  = pc_q;
   assign inst_valid = (state_q == FS_DELIV);
   assign inst_word  = word_q;
   assign inst_pc    = ipc_q;

   // Next-state logic for the fetch FSM, pending-redirect slot and kill flag
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      kill_d    = kill_q;
      word_d    = word_q;
      ipc_d     = ipc_q;
      fetch_inc = 1'b0;
      flush_inc = 1'b0;
      case (state_q)
         FS_IDLE: begin
            state_d = FS_REQ;
            if (redir_eff) pc_d = redir_tgt;
         end
         FS_REQ: begin
            // The address must stay put until granted, so a redirect is parked
            // in the pending slot and the granted fetch is marked for discard.
            if (redir_eff) begin
               pend_d    = 1'b1;
               pend_pc_d = redir_tgt;
            end
            if (imem_gnt) begin
               state_d = FS_WAIT;
               kill_d  = pend_q || redir_eff;
            end
         end
         FS_WAIT: begin
            if (redir_eff) begin
               if (imem_rvalid) begin
                  state_d   = FS_REQ;
                  pc_d      = redir_tgt;
                  pend_d    = 1'b0;
                  kill_d    = 1'b0;
                  flush_inc = 1'b1;
               end else begin
                  kill_d    = 1'b1;
                  pend_d    = 1'b1;
                  pend_pc_d = redir_tgt;
               end
            end else if (imem_rvalid) begin
               if (kill_q) begin
                  state_d   = FS_REQ;
                  pc_d      = pend_pc_q;
                  pend_d    = 1'b0;
                  kill_d    = 1'b0;
                  flush_inc = 1'b1;
               end else begin
                  state_d = FS_DELIV;
                  word_d  = imem_rdata;
                  ipc_d   = pc_q;
               end
            end
         end
         FS_DELIV: begin
            // A redirect wins over a simultaneous transfer
            if (redir_eff) begin
               state_d   = FS_REQ;
               pc_d      = redir_tgt;
               flush_inc = 1'b1;
            end else if (inst_ready) begin
               state_d   = FS_REQ;
               pc_d      = pc_q + 32'd4;
               fetch_inc = 1'b1;
            end
         end
         default: state_d = FS_IDLE;
      endcase
   end

   // Fetch state registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FS_IDLE;
         pc_q      <= RESET_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         kill_q    <= 1'b0;
         word_q    <= '0;
         ipc_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         kill_q    <= kill_d;
         word_q    <= word_d;
         ipc_q     <= ipc_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_flush_q;

   // Delivered / discarded fetch counters, free-running with wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (fetch_inc) perf_fetch_q <= perf_fetch_q + 32'd1;
         if (flush_inc) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_fetch = perf_fetch_q;
   assign perf_flush = perf_flush_q;
`else
   logic unused_perf;
   assign unused_perf = fetch_inc ^ flush_inc;
   assign perf_fetch  = '0;
   assign perf_flush  = '0;
`endif

endmodule : fetch_seq

// File: tb/tb_fetch_seq.sv
// Directed testbench for fetch_seq: sequential fetch, beq/j/jr redirects in
// each FSM state, ignored redirects, reset mid-fetch and PC wrap.
module tb_fetch_seq;

`ifdef FETCH_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_word;
   logic [31:0] inst_pc;
   logic        redir_valid;
   logic [1:0]  redir_sel;
   logic [31:0] redir_pc;
   logic [31:0] redir_imm;
   logic        redir_zero;
   logic [31:0] redir_base;
   logic [31:0] perf_fetch;
   logic [31:0] perf_flush;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_word   (inst_word),
      .inst_pc     (inst_pc),
      .redir_valid (redir_valid),
      .redir_sel   (redir_sel),
      .redir_pc    (redir_pc),
      .redir_imm   (redir_imm),
      .redir_zero  (redir_zero),
      .redir_base  (redir_base),
      .perf_fetch  (perf_fetch),
      .perf_flush  (perf_flush)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pexp(input int n);
      return PERF_ON ? 32'(n) : 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_redir();
      redir_valid = 1'b0;
      redir_sel   = 2'b00;
      redir_pc    = '0;
      redir_imm   = '0;
      redir_zero  = 1'b0;
      redir_base  = '0;
   endtask

   task automatic set_redir(input logic [1:0] sel, input logic [31:0] pc,
                            input logic [31:0] imm, input logic zero,
                            input logic [31:0] base);
      redir_valid = 1'b1;
      redir_sel   = sel;
      redir_pc    = pc;
      redir_imm   = imm;
      redir_zero  = zero;
      redir_base  = base;
   endtask

   // Full fetch from REQ: gnt same cycle, rvalid next, ready on delivery
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] w);
      chk("req_hi",   32'(imem_req), 32'd1);
      chk("req_addr", imem_addr, a);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      chk("wait_req", 32'(imem_req), 32'd0);
      chk("wait_vld", 32'(inst_valid), 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = w;
      tick();
      imem_rvalid = 1'b0;
      chk("dlv_vld",  32'(inst_valid), 32'd1);
      chk("dlv_word", inst_word, w);
      chk("dlv_pc",   inst_pc, a);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("post_vld", 32'(inst_valid), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      inst_ready  = 1'b0;
      clr_redir();

      // Reset state
      tick();
      tick();
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_vld",   32'(inst_valid), 32'd0);
      chk("rst_word",  inst_word, 32'd0);
      chk("rst_pc",    inst_pc, 32'd0);
      chk("rst_pfet",  perf_fetch, 32'd0);
      chk("rst_pfl",   perf_flush, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: three sequential fetches
      do_fetch(32'h0000_3000, 32'hA000_0001);
      do_fetch(32'h0000_3004, 32'hA000_0002);
      do_fetch(32'h0000_3008, 32'hA000_0003);
      chk("t1_next",  imem_addr, 32'h0000_300C);
      chk("t1_pfet",  perf_fetch, pexp(3));

      // 2: taken beq during WAIT, response dropped, refetch at 3000
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      set_redir(2'b01, 32'h0000_3004, 32'h0000_FFFE, 1'b1, 32'h0);
      tick();
      clr_redir();
      chk("t2_wreq",  32'(imem_req), 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_0002;
      tick();
      imem_rvalid = 1'b0;
      chk("t2_vld",   32'(inst_valid), 32'd0);
      chk("t2_pfl",   perf_flush, pexp(1));
      do_fetch(32'h0000_3000, 32'hB000_0000);

      // 3: untaken beq and seq redirects are ignored
      chk("t3_addr",  imem_addr, 32'h0000_3004);
      set_redir(2'b01, 32'h0000_1000, 32'h0000_0010, 1'b0, 32'h0);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      set_redir(2'b00, 32'h0000_2000, 32'h0, 1'b0, 32'h0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hC000_0003;
      tick();
      clr_redir();
      imem_rvalid = 1'b0;
      chk("t3_vld",   32'(inst_valid), 32'd1);
      chk("t3_pc",    inst_pc, 32'h0000_3004);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("t3_next",  imem_addr, 32'h0000_3008);
      chk("t3_pfl",   perf_flush, pexp(1));

      // 4: j during REQ with gnt low for 3 cycles
      set_redir(2'b10, 32'h0000_3000, 32'h0000_0C10, 1'b0, 32'h0);
      tick();
      clr_redir();
      chk("t4_hold1", imem_addr, 32'h0000_3008);
      chk("t4_req1",  32'(imem_req), 32'd1);
      tick();
      chk("t4_hold2", imem_addr, 32'h0000_3008);
      tick();
      chk("t4_hold3", imem_addr, 32'h0000_3008);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_0004;
      tick();
      imem_rvalid = 1'b0;
      chk("t4_vld",   32'(inst_valid), 32'd0);
      chk("t4_req",   32'(imem_req), 32'd1);
      chk("t4_pfl",   perf_flush, pexp(2));
      do_fetch(32'h0000_3040, 32'hD000_0004);

      // 5: jr in DELIVER beats a simultaneous transfer
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hE000_0005;
      tick();
      imem_rvalid = 1'b0;
      chk("t5_vld",   32'(inst_valid), 32'd1);
      chk("t5_pc",    inst_pc, 32'h0000_3044);
      inst_ready = 1'b1;
      set_redir(2'b11, 32'h0000_3044, 32'h0, 1'b0, 32'h0000_4000);
      tick();
      clr_redir();
      inst_ready = 1'b0;
      chk("t5_vld0",  32'(inst_valid), 32'd0);
      chk("t5_addr",  imem_addr, 32'h0000_4000);
      chk("t5_pfet",  perf_fetch, pexp(6));
      chk("t5_pfl",   perf_flush, pexp(3));
      do_fetch(32'h0000_4000, 32'hF000_0005);

      // 6: reset during WAIT, late rvalid ignored
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_req",   32'(imem_req), 32'd0);
      chk("t6_vld",   32'(inst_valid), 32'd0);
      chk("t6_pc",    inst_pc, 32'd0);
      chk("t6_word",  inst_word, 32'd0);
      chk("t6_pfet",  perf_fetch, 32'd0);
      tick();
      rst_n = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_0006;
      tick();
      chk("t6_vld1",  32'(inst_valid), 32'd0);
      chk("t6_addr",  imem_addr, 32'h0000_3000);
      tick();
      imem_rvalid = 1'b0;
      chk("t6_vld2",  32'(inst_valid), 32'd0);
      chk("t6_addr2", imem_addr, 32'h0000_3000);
      do_fetch(32'h0000_3000, 32'h1234_5678);

      // 7: jr with gnt in the same cycle, then pc+4 wraps to zero
      set_redir(2'b11, 32'h0000_3000, 32'h0, 1'b0, 32'hFFFF_FFFC);
      imem_gnt = 1'b1;
      tick();
      clr_redir();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_0007;
      tick();
      imem_rvalid = 1'b0;
      chk("t7_vld",   32'(inst_valid), 32'd0);
      chk("t7_pfl",   perf_flush, pexp(1));
      do_fetch(32'hFFFF_FFFC, 32'h7777_0007);
      chk("t7_wrap",  imem_addr, 32'h0000_0000);
      chk("t7_pfet",  perf_fetch, pexp(2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_seq
